// File: rtl/regfile_pkg.sv
// Shared sizing constants and dump-state encoding for the register file slice.
package regfile_pkg;

    localparam int RF_XLEN       = 64;
    localparam int RF_NREG       = 32;
    localparam int RF_ADDR_W     = $clog2(RF_NREG);
    localparam int RF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } dump_state_e;

endpackage

// File: rtl/regfile_arb.sv
// Write-port arbiter: the pipeline writeback wins by default; the debug port
// is granted when writeback is idle or after it has waited STARVE_MAX cycles.
module regfile_arb
    import regfile_pkg::*;
#(
    parameter int STARVE_MAX = RF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic wb_en_i,
    input  logic dbg_valid_i,
    output logic wb_ready_o,
    output logic dbg_ready_o
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q, starve_d;
    logic          dbg_win;

    always_comb begin
        dbg_win  = !rst && dbg_valid_i && (!wb_en_i || (starve_q == CW'(STARVE_MAX)));
        starve_d = starve_q;
        if (!dbg_valid_i || dbg_win) begin
            starve_d = '0;
        end else if (starve_q != CW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign wb_ready_o  = !dbg_win;
    assign dbg_ready_o = dbg_win;

endmodule

// File: rtl/regfile_ctrl.sv
// Integer register file with two bypassing read ports, arbitrated wb/debug
// write port and a register dump streamer that runs alongside normal traffic.
module regfile_ctrl
    import regfile_pkg::*;
#(
    parameter int XLEN       = RF_XLEN,
    parameter int NREG       = RF_NREG,
    parameter int STARVE_MAX = RF_STARVE_MAX,
    localparam int AW        = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_ready,
    input  logic            dbg_valid,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [XLEN-1:0] dbg_data,
    output logic            dbg_ready,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic            dump_start,
    output logic            dump_busy,
    output logic            dump_valid,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_done
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    dump_state_e     state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;

    regfile_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .wb_en_i     (wb_en),
        .dbg_valid_i (dbg_valid),
        .wb_ready_o  (wb_ready),
        .dbg_ready_o (dbg_ready)
    );

    // Exactly one requester reaches the storage; dbg_ready already excludes reset.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wb_addr;
        wr_data = wb_data;
        if (dbg_ready) begin
            wr_en   = 1'b1;
            wr_addr = dbg_addr;
            wr_data = dbg_data;
        end else if (wb_en && !rst) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    function automatic logic [XLEN-1:0] rd_val(input logic [AW-1:0] a);
        if (a == '0) begin
            return '0;
        end
        if (wr_en && (wr_addr == a)) begin
            return wr_data;
        end
        return regs_q[a];
    endfunction

    always_comb begin
        rs1_data = rd_val(rs1_addr);
        rs2_data = rd_val(rs2_addr);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dump_busy  = 1'b0;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        dump_idx   = '0;
        dump_data  = '0;
        case (state_q)
            ST_IDLE: begin
                if (dump_start) begin
                    state_d = ST_DUMP;
                    idx_d   = '0;
                end
            end
            ST_DUMP: begin
                dump_busy  = 1'b1;
                dump_valid = 1'b1;
                dump_idx   = idx_q;
                dump_data  = rd_val(idx_q);
                if (idx_q == AW'(NREG - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                dump_busy = 1'b1;
                dump_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Status is forced quiet while reset is held, even if a dump was in flight.
        if (rst) begin
            dump_busy  = 1'b0;
            dump_valid = 1'b0;
            dump_done  = 1'b0;
            dump_idx   = '0;
            dump_data  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl: dump beats go through a scoreboard queue
// checked by a monitor; port-level responses are checked inline.
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        wb_ready;
    logic        dbg_valid;
    logic [4:0]  dbg_addr;
    logic [63:0] dbg_data;
    logic        dbg_ready;
    logic [4:0]  rs1_addr;
    logic [63:0] rs1_data;
    logic [4:0]  rs2_addr;
    logic [63:0] rs2_data;
    logic        dump_start;
    logic        dump_busy;
    logic        dump_valid;
    logic [4:0]  dump_idx;
    logic [63:0] dump_data;
    logic        dump_done;

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests    = 0;
    int    n_fail     = 0;
    int    beats_seen = 0;

    always #5 clk = ~clk;

    regfile_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .dbg_valid  (dbg_valid),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .dbg_ready  (dbg_ready),
        .rs1_addr   (rs1_addr),
        .rs1_data   (rs1_data),
        .rs2_addr   (rs2_addr),
        .rs2_data   (rs2_data),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    // Waits (bounded) for dump_done; optionally pokes dump_start mid-dump.
    task automatic wait_done(input bit poke, output bit got);
        int cyc;
        cyc = 0;
        got = 1'b0;
        while (cyc < 40 && !got) begin
            sample;
            if (dump_done) begin
                got = 1'b1;
            end else begin
                tick;
                cyc++;
                dump_start = poke && (cyc == 5);
            end
        end
        dump_start = 1'b0;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (dump_valid) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dump_unexpected: idx %0d data 0x%0h, no beat expected", dump_idx, dump_data);
            end else begin
                e = exp_q.pop_front();
                check("dump_idx", {59'd0, dump_idx}, {59'd0, e.idx});
                check("dump_data", dump_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit got;
        rst = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'hDEAD;
        dbg_valid = 1'b1; dbg_addr = 5'd6; dbg_data = 64'hBEEF;
        rs1_addr = 5'd5; rs2_addr = 5'd6; dump_start = 1'b1;

        // Reset with all requesters active
        tick; sample;
        check("rst_wb_ready", wb_ready, 1);
        check("rst_dbg_ready", dbg_ready, 0);
        check("rst_dump_busy", dump_busy, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dump_done", dump_done, 0);
        tick; sample;
        check("rst_rs1_no_bypass", rs1_data, 0);
        tick;
        rst = 1'b0; wb_en = 1'b0; dbg_valid = 1'b0; dump_start = 1'b0;
        sample;
        check("rst_x5_clear", rs1_data, 0);
        check("rst_x6_clear", rs2_data, 0);
        check("rst_no_dump", dump_busy, 0);

        // Same-cycle bypass then stored value
        tick;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h1234; rs1_addr = 5'd5; rs2_addr = 5'd0;
        sample;
        check("byp_rs1", rs1_data, 64'h1234);
        check("byp_wb_ready", wb_ready, 1);
        check("byp_rs2_x0", rs2_data, 0);
        tick;
        wb_en = 1'b0;
        sample;
        check("x5_stored", rs1_data, 64'h1234);

        // Write to x0 is accepted but discarded
        tick;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 64'hFFFF; rs1_addr = 5'd0;
        sample;
        check("x0_wb_ready", wb_ready, 1);
        check("x0_no_bypass", rs1_data, 0);
        tick;
        wb_en = 1'b0;
        sample;
        check("x0_after", rs1_data, 0);

        // Debug write with wb idle is granted at once
        tick;
        dbg_valid = 1'b1; dbg_addr = 5'd8; dbg_data = 64'h88;
        sample;
        check("dbg_idle_ready", dbg_ready, 1);
        check("dbg_idle_wb_ready", wb_ready, 0);
        tick;
        dbg_valid = 1'b0; rs1_addr = 5'd8;
        sample;
        check("x8_stored", rs1_data, 64'h88);

        // Starvation: wb busy every cycle, dbg forced in on the 5th
        tick;
        dbg_valid = 1'b1; dbg_addr = 5'd7; dbg_data = 64'hAB;
        wb_en = 1'b1; wb_addr = 5'd9; rs2_addr = 5'd7;
        for (int c = 1; c <= 5; c++) begin
            wb_data = 64'h900 + 64'(c);
            sample;
            check($sformatf("starve_dbg_ready_c%0d", c), dbg_ready, (c == 5));
            check($sformatf("starve_wb_ready_c%0d", c), wb_ready, (c != 5));
            if (c < 5) tick;
        end
        check("starve_rs2_bypass", rs2_data, 64'hAB);
        tick;
        dbg_valid = 1'b0; wb_en = 1'b0; rs1_addr = 5'd9; rs2_addr = 5'd7;
        sample;
        check("x7_dbg_stored", rs2_data, 64'hAB);
        check("x9_last_wb", rs1_data, 64'h904);

        // Preload x1..x31 = n and dump everything
        for (int n = 1; n < 32; n++) begin
            tick;
            wb_en = 1'b1; wb_addr = 5'(n); wb_data = 64'(n);
        end
        tick;
        wb_en = 1'b0;
        for (int i = 0; i < 32; i++) exp_q.push_back('{idx: 5'(i), data: 64'(i)});
        beats_seen = 0;
        dump_start = 1'b1;
        sample;
        check("start_cycle_valid", dump_valid, 0);
        tick;
        dump_start = 1'b0;
        wait_done(1'b1, got);
        check("dump1_done_seen", got, 1);
        check("dump1_beats", 64'(beats_seen), 32);
        check("dump1_queue_empty", 64'(exp_q.size()), 0);
        check("dump1_busy_in_done", dump_busy, 1);
        tick; sample;
        check("dump1_busy_after", dump_busy, 0);
        check("dump1_done_after", dump_done, 0);
        check("dump1_valid_after", dump_valid, 0);

        // wb write to x3 on the idx-3 beat is seen through the bypass
        for (int i = 0; i < 32; i++) exp_q.push_back('{idx: 5'(i), data: (i == 3) ? 64'h55 : 64'(i)});
        beats_seen = 0;
        tick;
        dump_start = 1'b1;
        tick;
        dump_start = 1'b0;
        repeat (3) tick;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'h55;
        sample;
        check("dump_wb_ready", wb_ready, 1);
        tick;
        wb_en = 1'b0;
        wait_done(1'b0, got);
        check("dump2_done_seen", got, 1);
        check("dump2_beats", 64'(beats_seen), 32);
        check("dump2_queue_empty", 64'(exp_q.size()), 0);
        rs1_addr = 5'd3;
        #1;
        check("x3_stored", rs1_data, 64'h55);

        // Reset at beat 10 aborts the dump and clears storage
        for (int i = 0; i < 10; i++) exp_q.push_back('{idx: 5'(i), data: (i == 3) ? 64'h55 : 64'(i)});
        beats_seen = 0;
        tick;
        dump_start = 1'b1;
        tick;
        dump_start = 1'b0;
        repeat (10) tick;
        rst = 1'b1;
        sample;
        check("midrst_valid_in_rst", dump_valid, 0);
        tick;
        rst = 1'b0;
        sample;
        check("midrst_valid", dump_valid, 0);
        check("midrst_busy", dump_busy, 0);
        check("midrst_done", dump_done, 0);
        check("midrst_beats", 64'(beats_seen), 10);
        check("midrst_queue_empty", 64'(exp_q.size()), 0);
        for (int r = 0; r < 32; r++) begin
            tick;
            rs1_addr = 5'(r); rs2_addr = 5'(31 - r);
            sample;
            check($sformatf("midrst_rs1_x%0d", r), rs1_data, 0);
            check($sformatf("midrst_rs2_x%0d", 31 - r), rs2_data, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
